tlc_phase_scheduler: RTL and testbench

TLC_PHASE_SCHEDULER -- requirements
Module: tlc_phase_scheduler

---
 rtl/tlc_pkg.sv | 24 ++
 rtl/tlc_queue_counter.sv | 35 +++
 rtl/tlc_phase_scheduler.sv | 113 +++++++++++
 tb/tb_tlc_phase_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the two-approach traffic-light phase scheduler:
// phase encoding, one-hot light codes and default timing.
package tlc_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_TO_EW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_TO_NS = 3'd5
    } phase_t;

    // Light encoding is one-hot {red, yellow, green}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int unsigned DEF_MIN_GREEN = 4;
    localparam int unsigned DEF_MAX_GREEN = 12;
    localparam int unsigned DEF_YELLOW_T  = 2;
    localparam int unsigned DEF_ALL_RED_T = 1;

endpackage

// File: rtl/tlc_queue_counter.sv
// Per-approach saturating queue occupancy: one car in per arrival pulse,
// two cars out per departure tick, clamped to 0..15.
module tlc_queue_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       arrive,
    input  logic       depart,
    output logic [3:0] count
);

    logic [4:0] sum;
    logic [4:0] count_next;

    // Add first, then remove, so arrival and departure together net to -1
    always_comb begin
        sum        = {1'b0, count} + {4'b0000, arrive};
        count_next = sum;
        if (depart) begin
            count_next = (sum >= 5'd2) ? (sum - 5'd2) : '0;
        end
        if (count_next > 5'd15) begin
            count_next = 5'd15;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count_next[3:0];
        end
    end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Two-approach traffic-light scheduler: six-phase cyclic FSM with a
// tick-driven phase timer and demand-aware green yielding.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
    parameter int unsigned MAX_GREEN = DEF_MAX_GREEN,
    parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
    parameter int unsigned ALL_RED_T = DEF_ALL_RED_T
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       tick,
    input  logic       car_ns,
    input  logic       car_ew,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [3:0] ns_count,
    output logic [3:0] ew_count,
    output logic [2:0] phase
);

    phase_t     state;
    phase_t     state_next;
    logic [3:0] timer;
    logic [4:0] elapsed;
    logic       ns_depart;
    logic       ew_depart;

    assign ns_depart = tick && (state == NS_GREEN);
    assign ew_depart = tick && (state == EW_GREEN);

    tlc_queue_counter u_ns_queue (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .arrive (car_ns),
        .depart (ns_depart),
        .count  (ns_count)
    );

    tlc_queue_counter u_ew_queue (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .arrive (car_ew),
        .depart (ew_depart),
        .count  (ew_count)
    );

    // Green decisions use the tick count as it will be after this tick
    assign elapsed = {1'b0, timer} + 5'd1;

    always_comb begin
        state_next = state;
        if (tick) begin
            unique case (state)
                NS_GREEN: begin
                    if ((ew_count != '0) &&
                        (((ns_count == '0) && (elapsed >= 5'(MIN_GREEN))) ||
                         (elapsed >= 5'(MAX_GREEN)))) begin
                        state_next = NS_YELLOW;
                    end
                end
                NS_YELLOW: if (timer == 4'(YELLOW_T - 1))  state_next = RED_TO_EW;
                RED_TO_EW: if (timer == 4'(ALL_RED_T - 1)) state_next = EW_GREEN;
                EW_GREEN: begin
                    if ((ns_count != '0) &&
                        (((ew_count == '0) && (elapsed >= 5'(MIN_GREEN))) ||
                         (elapsed >= 5'(MAX_GREEN)))) begin
                        state_next = EW_YELLOW;
                    end
                end
                EW_YELLOW: if (timer == 4'(YELLOW_T - 1))  state_next = RED_TO_NS;
                RED_TO_NS: if (timer == 4'(ALL_RED_T - 1)) state_next = NS_GREEN;
                default:   state_next = NS_GREEN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= NS_GREEN;
            timer <= '0;
        end else if (en) begin
            state <= state_next;
            if (state_next != state) begin
                timer <= '0;
            end else if (tick && (timer != 4'd15)) begin
                timer <= timer + 4'd1;
            end
        end
    end

    always_comb begin
        ns_light = RED;
        ew_light = RED;
        unique case (state)
            NS_GREEN:  ns_light = GRN;
            NS_YELLOW: ns_light = YEL;
            EW_GREEN:  ew_light = GRN;
            EW_YELLOW: ew_light = YEL;
            default: begin
                ns_light = RED;
                ew_light = RED;
            end
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed self-checking bench for tlc_phase_scheduler with default timing.
module tb_tlc_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic       tick = 1'b0;
    logic       car_ns = 1'b0;
    logic       car_ew = 1'b0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [3:0] ns_count;
    logic [3:0] ew_count;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] P_NSG = 3'd0;
    localparam logic [2:0] P_NSY = 3'd1;
    localparam logic [2:0] P_REW = 3'd2;
    localparam logic [2:0] P_EWG = 3'd3;
    localparam logic [2:0] P_EWY = 3'd4;
    localparam logic [2:0] P_RNS = 3'd5;

    tlc_phase_scheduler #(
        .MIN_GREEN (4),
        .MAX_GREEN (12),
        .YELLOW_T  (2),
        .ALL_RED_T (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .tick     (tick),
        .car_ns   (car_ns),
        .car_ew   (car_ew),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .ns_count (ns_count),
        .ew_count (ew_count),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    // One clock with the given pulses; returns 1 time unit after the edge
    task automatic step(input logic cn, input logic ce, input logic tk);
        car_ns = cn;
        car_ew = ce;
        tick   = tk;
        @(posedge clk);
        #1;
        car_ns = 1'b0;
        car_ew = 1'b0;
        tick   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        en    = 1'b1;
        checks++;
        if (phase !== P_NSG) begin errors++; $display("FAIL reset_phase got %0d exp %0d", phase, P_NSG); end
        checks++;
        if (ns_count !== 4'd0 || ew_count !== 4'd0) begin
            errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", ns_count, ew_count);
        end
        checks++;
        if (ns_light !== 3'b001 || ew_light !== 3'b100) begin
            errors++; $display("FAIL reset_lights got %b/%b exp 001/100", ns_light, ew_light);
        end
        // reset wins over same-cycle arrivals and ticks with en high
        step(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        checks++;
        if (ns_count !== 4'd0 || ew_count !== 4'd0 || phase !== P_NSG) begin
            errors++; $display("FAIL reset_priority got %0d/%0d ph %0d exp 0/0 ph 0", ns_count, ew_count, phase);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_NSG || ns_light !== 3'b001 || ns_count !== 4'd0 || ew_count !== 4'd0) begin
            errors++; $display("FAIL idle got ph %0d ns_light %b cnt %0d/%0d exp ph 0 001 0/0",
                               phase, ns_light, ns_count, ew_count);
        end
    endtask

    task automatic test_min_green_cycle();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        checks++;
        if (ew_count !== 4'd3) begin errors++; $display("FAIL ew_arrivals got %0d exp 3", ew_count); end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (phase !== P_NSG) begin errors++; $display("FAIL ns_hold tick %0d got %0d exp %0d", i, phase, P_NSG); end
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_NSY || ns_light !== 3'b010 || ew_light !== 3'b100) begin
            errors++; $display("FAIL ns_yield got ph %0d %b/%b exp ph 1 010/100", phase, ns_light, ew_light);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_NSY) begin errors++; $display("FAIL ns_yellow1 got %0d exp %0d", phase, P_NSY); end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_REW || ns_light !== 3'b100 || ew_light !== 3'b100) begin
            errors++; $display("FAIL all_red_ew got ph %0d %b/%b exp ph 2 100/100", phase, ns_light, ew_light);
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_EWG || ew_light !== 3'b001 || ns_light !== 3'b100 || ew_count !== 4'd3) begin
            errors++; $display("FAIL ew_green got ph %0d %b/%b cnt %0d exp ph 3 100/001 3",
                               phase, ns_light, ew_light, ew_count);
        end
        // EW drains while NS is empty: green held
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_EWG || ew_count !== 4'd0) begin
            errors++; $display("FAIL ew_hold got ph %0d cnt %0d exp ph 3 cnt 0", phase, ew_count);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_EWY || ew_light !== 3'b010) begin
            errors++; $display("FAIL ew_yield got ph %0d ew_light %b exp ph 4 010", phase, ew_light);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_RNS) begin errors++; $display("FAIL all_red_ns got %0d exp %0d", phase, P_RNS); end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_NSG || ns_count !== 4'd1) begin
            errors++; $display("FAIL wrap_ns_green got ph %0d cnt %0d exp ph 0 cnt 1", phase, ns_count);
        end
    endtask

    task automatic test_departures();
        logic [3:0] exp_ns [3];
        exp_ns[0] = 4'd3; exp_ns[1] = 4'd1; exp_ns[2] = 4'd0;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            checks++;
            if (ns_count !== exp_ns[i] || phase !== P_NSG) begin
                errors++; $display("FAIL drain tick %0d got cnt %0d ph %0d exp cnt %0d ph 0",
                                   i + 1, ns_count, phase, exp_ns[i]);
            end
        end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_NSY || ew_count !== 4'd2) begin
            errors++; $display("FAIL min_yield got ph %0d ew %0d exp ph 1 ew 2", phase, ew_count);
        end
    endtask

    task automatic test_max_green();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b1);
            checks++;
            if (phase !== P_NSG || ns_count !== 4'd5) begin
                errors++; $display("FAIL max_hold tick %0d got ph %0d cnt %0d exp ph 0 cnt 5", i, phase, ns_count);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (phase !== P_NSY) begin errors++; $display("FAIL max_yield got %0d exp %0d", phase, P_NSY); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (ns_count !== 4'd15) begin errors++; $display("FAIL sat_high got %0d exp 15", ns_count); end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (ns_count !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", ns_count); end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (ns_count !== 4'd4) begin errors++; $display("FAIL net_5_to_4 got %0d exp 4", ns_count); end
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (ns_count !== 4'd1) begin errors++; $display("FAIL pre_one got %0d exp 1", ns_count); end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (ns_count !== 4'd0) begin errors++; $display("FAIL net_1_to_0 got %0d exp 0", ns_count); end
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (ns_count !== 4'd0) begin errors++; $display("FAIL floor_0 got %0d exp 0", ns_count); end
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (ns_count !== 4'd0 || phase !== P_NSG) begin
            errors++; $display("FAIL one_minus_two got cnt %0d ph %0d exp 0 ph 0", ns_count, phase);
        end
    endtask

    task automatic test_enable();
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        checks++;
        if (phase !== P_NSG || ns_count !== 4'd0 || ew_count !== 4'd2) begin
            errors++; $display("FAIL en_low got ph %0d cnt %0d/%0d exp ph 0 0/2", phase, ns_count, ew_count);
        end
        en = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_NSY) begin errors++; $display("FAIL en_resume got %0d exp %0d", phase, P_NSY); end
    endtask

    task automatic test_reset_mid_phase();
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== P_EWY || ns_count !== 4'd1) begin
            errors++; $display("FAIL reach_ew_yellow got ph %0d ns %0d exp ph 4 ns 1", phase, ns_count);
        end
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        checks++;
        if (phase !== P_NSG || ns_count !== 4'd0 || ew_count !== 4'd0 || ns_light !== 3'b001) begin
            errors++; $display("FAIL mid_reset got ph %0d cnt %0d/%0d light %b exp ph 0 0/0 001",
                               phase, ns_count, ew_count, ns_light);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_idle();
        test_min_green_cycle();
        test_departures();
        test_max_green();
        test_saturation();
        test_enable();
        test_reset_mid_phase();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
